// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch-stage sequencer: reset fetch address and
// FSM state encodings.
package fetch_seq_pkg;

  localparam int          ADDR_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Fetch output buffer: one visible slot for the D stage plus a one-entry skid.
// A push lands in the slot when it is empty or leaving, otherwise in the skid.
import fetch_seq_pkg::*;

module fetch_buf #(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [31:0]       push_instr,
  input  logic              accept,
  input  logic              flush,
  output logic              slot_v,
  output logic [ADDR_W-1:0] slot_pc,
  output logic [31:0]       slot_instr,
  output logic              skid_v
);

  logic              slot_v_d;
  logic              skid_v_d;
  logic              take_skid;
  logic              load_slot;
  logic              load_skid;
  logic [ADDR_W-1:0] skid_pc;
  logic [31:0]       skid_instr;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    slot_v_d  = slot_v;
    skid_v_d  = skid_v;
    take_skid = 1'b0;
    load_slot = 1'b0;
    load_skid = 1'b0;
    if (flush) begin
      slot_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (accept && skid_v) begin
      take_skid = 1'b1;
      skid_v_d  = push;
      load_skid = push;
    end else if (accept || !slot_v) begin
      slot_v_d  = push;
      load_slot = push;
    end else if (push) begin
      skid_v_d  = 1'b1;
      load_skid = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_v     <= 1'b0;
      skid_v     <= 1'b0;
      slot_pc    <= RESET_PC;
      slot_instr <= 32'd0;
    end else begin
      slot_v <= slot_v_d;
      skid_v <= skid_v_d;
      if (take_skid) begin
        slot_pc    <= skid_pc;
        slot_instr <= skid_instr;
      end else if (load_slot) begin
        slot_pc    <= push_pc;
        slot_instr <= push_instr;
      end
    end
  end

  // NOTE: skid payload is qualified by skid_v, so it carries no reset and
  // lives in its own reset-free process.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_pc    <= push_pc;
      skid_instr <= push_instr;
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Fetch-stage sequencer: owns the fetch PC, issues IM requests, buffers
// fetched words for D and applies redirects with MIPS delay-slot semantics.
import fetch_seq_pkg::*;

module fetch_seq #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ready,
  input  logic [31:0]       im_rdata,
  output logic              f_valid,
  output logic [ADDR_W-1:0] f_pc,
  output logic [31:0]       f_instr,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              outst_q, outst_d;
  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

  logic slot_v;
  logic skid_v;
  logic accept;
  logic push;
  logic flush;
  logic redirect_take;

  assign accept        = slot_v && !stall;
  assign redirect_take = redirect_valid && !stall;
  assign f_valid       = slot_v;
  assign fetch_pc      = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    outst_d    = outst_q;
    pend_v_d   = pend_v_q;
    pend_pc_d  = pend_pc_q;
    im_req     = 1'b0;
    im_addr    = pc_q;
    push       = 1'b0;
    flush      = 1'b0;

    unique case (state_q)
      FS_IDLE: begin
        state_d = FS_REQ;
        if (redirect_take) begin
          pend_v_d  = 1'b1;
          pend_pc_d = redirect_pc;
        end
      end

      FS_REQ: begin
        im_req  = outst_q || (!skid_v && (!slot_v || !stall));
        im_addr = outst_q ? req_addr_q : pc_q;
        if (redirect_take && slot_v) begin
          // Delay slot is leaving the slot now: everything younger is wrong-path.
          flush    = 1'b1;
          pc_d     = redirect_pc;
          pend_v_d = 1'b0;
          if (im_req && !im_ready) begin
            state_d    = FS_DROP;
            outst_d    = 1'b1;
            req_addr_d = im_addr;
          end else begin
            outst_d = 1'b0;
          end
        end else if (im_req && im_ready) begin
          push     = 1'b1;
          outst_d  = 1'b0;
          pend_v_d = 1'b0;
          if (redirect_take) begin
            pc_d = redirect_pc;
          end else begin
            pc_d = pend_v_q ? pend_pc_q : pc_q + ADDR_W'(4);
          end
        end else if (im_req) begin
          outst_d    = 1'b1;
          req_addr_d = im_addr;
          // Delay-slot fetch still in flight: remember the target for later.
          if (redirect_take) begin
            pend_v_d  = 1'b1;
            pend_pc_d = redirect_pc;
          end
        end
      end

      FS_DROP: begin
        im_req  = 1'b1;
        im_addr = req_addr_q;
        if (im_ready) begin
          outst_d = 1'b0;
          state_d = FS_REQ;
        end
        if (redirect_take) begin
          pend_v_d  = 1'b1;
          pend_pc_d = redirect_pc;
        end
      end

      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FS_IDLE;
      pc_q       <= PC_RST;
      req_addr_q <= PC_RST;
      outst_q    <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_pc_q  <= PC_RST;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      outst_q    <= outst_d;
      pend_v_q   <= pend_v_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  fetch_buf #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (PC_RST)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_pc    (im_addr),
    .push_instr (im_rdata),
    .accept     (accept),
    .flush      (flush),
    .slot_v     (slot_v),
    .slot_pc    (f_pc),
    .slot_instr (f_instr),
    .skid_v     (skid_v)
  );

endmodule
